// File: rtl/alu_bist_controller.sv
// ---------------------------------------------------------------------------
// alu_bist_controller
//
// Built-in self-test engine for an 8-bit ALU. For each of the 8 select codes
// it applies NUM_VECTORS pseudo-random operand pairs from a 16-bit Galois
// LFSR. Every ALU response {carry, y} is folded into a 16-bit MISR whose
// contents form the run signature. The LFSR restarts from its seed for each
// select code, so every operation sees the same operand sequence.
//
// Each vector takes two cycles. In DRIVE the operands settle through the ALU.
// In SAMPLE the MISR absorbs the response. busy is therefore high for
// 16*NUM_VECTORS cycles per run.
//
// Optional feature: define ALU_BIST_GOLDEN_CMP_EN to add the GOLDEN_SIG
// parameter and the pass_o output. pass_o is registered on entry to DONE as
// (final signature == GOLDEN_SIG) and is cleared when a new run starts.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_i      begin a run (sampled only in IDLE)
//   busy_o       high while a run is in progress
//   done_o       one-cycle pulse after the last capture
//   alu_a_o      ALU operand A
//   alu_b_o      ALU operand B
//   alu_sel_o    ALU operation select
//   alu_y_i      ALU result
//   alu_carry_i  ALU carry
//   signature_o  MISR contents; holds the final value after done
//   pass_o       (ALU_BIST_GOLDEN_CMP_EN only) signature matched GOLDEN_SIG
// ---------------------------------------------------------------------------
module alu_bist_controller #(
  parameter int          WIDTH       = 8,
  parameter int          NUM_VECTORS = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [15:0] MISR_SEED   = 16'h0000
`ifdef ALU_BIST_GOLDEN_CMP_EN
  ,
  parameter logic [15:0] GOLDEN_SIG  = 16'h0000
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_sel_o,
  input  logic [WIDTH-1:0] alu_y_i,
  input  logic             alu_carry_i,
  output logic [15:0]      signature_o
`ifdef ALU_BIST_GOLDEN_CMP_EN
  ,
  output logic             pass_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_e;

  // An all-zero seed would lock the LFSR at zero.
  localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [7:0]  VEC_LAST = 8'(NUM_VECTORS - 1);
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      misr_q, misr_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       vec_q, vec_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [15:0]      lfsr_next;
  logic [15:0]      misr_next;
  logic [15:0]      resp;

  // Galois LFSR step and MISR fold of the zero-extended {carry, y} response.
  assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
  assign resp      = {{(15 - WIDTH){1'b0}}, alu_carry_i, alu_y_i};
  assign misr_next = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? MISR_POLY : 16'h0000) ^ resp;

`ifdef ALU_BIST_GOLDEN_CMP_EN
  logic pass_q, pass_d;
`endif

  // NOTE: every signal this block assigns gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    sel_d   = sel_q;
    vec_d   = vec_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef ALU_BIST_GOLDEN_CMP_EN
    pass_d  = pass_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_DRIVE;
          lfsr_d  = SEED;
          misr_d  = MISR_SEED;
          sel_d   = 3'd0;
          vec_d   = 8'd0;
          a_d     = SEED[WIDTH-1:0];
          b_d     = SEED[15 -: WIDTH];
          busy_d  = 1'b1;
`ifdef ALU_BIST_GOLDEN_CMP_EN
          pass_d  = 1'b0;
`endif
        end
      end

      S_DRIVE: state_d = S_SAMPLE;

      S_SAMPLE: begin
        misr_d = misr_next;
        if (vec_q != VEC_LAST) begin
          state_d = S_DRIVE;
          vec_d   = vec_q + 8'd1;
          lfsr_d  = lfsr_next;
          a_d     = lfsr_next[WIDTH-1:0];
          b_d     = lfsr_next[15 -: WIDTH];
        end else if (sel_q != 3'd7) begin
          // Next operation replays the same operand sequence from the seed.
          state_d = S_DRIVE;
          sel_d   = sel_q + 3'd1;
          vec_d   = 8'd0;
          lfsr_d  = SEED;
          a_d     = SEED[WIDTH-1:0];
          b_d     = SEED[15 -: WIDTH];
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef ALU_BIST_GOLDEN_CMP_EN
          pass_d  = (misr_next == GOLDEN_SIG);
`endif
        end
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      misr_q  <= 16'h0000;
      sel_q   <= 3'd0;
      vec_q   <= 8'd0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      sel_q   <= sel_d;
      vec_q   <= vec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef ALU_BIST_GOLDEN_CMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pass_q <= 1'b0;
    else        pass_q <= pass_d;
  end

  assign pass_o = pass_q;
`endif

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign alu_sel_o   = sel_q;
  assign signature_o = misr_q;

endmodule
